restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have ports dividend and divisor, inputs, WIDTH bits each: unsigned operands, sampled on the accepting edge.
REQ-006 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-008 The block SHALL have ports quotient and remainder, outputs, WIDTH bits each: the registered results.
REQ-009 The block SHALL have port div_err, output, 1 bit: divide-by-zero flag, valid while done is high.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 IDLE with start=1 at edge k SHALL capture the operands, clear the partial remainder, load the iteration counter with 0 and go to RUN.
REQ-012 Each RUN cycle SHALL perform one restoring step, MSB first: shift {partial remainder, dividend bit} left; if the partial remainder is at least the divisor, subtract the divisor and set the quotient bit to 1, otherwise set it to 0.
REQ-013 The partial remainder SHALL be WIDTH+1 bits wide so that the comparison never overflows.
REQ-014 After WIDTH RUN cycles the FSM SHALL enter DONE, so done is high during the cycle following edge k+WIDTH+1.
REQ-015 On entry to DONE, quotient and remainder SHALL be loaded.
REQ-016 The FSM SHALL remain in DONE for exactly one cycle and then return to IDLE.
REQ-017 quotient and remainder SHALL hold their values until the next DONE entry.
REQ-018 start SHALL be ignored while busy=1; the operation in flight SHALL be unaffected.
REQ-019 start held high continuously SHALL produce back-to-back operations, one accepted in every IDLE cycle.
REQ-020 Operand input changes after acceptance SHALL have no effect on the operation in flight.
REQ-021 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every divisor other than 0.

Reset
REQ-022 Asserting rst_n low SHALL immediately force IDLE, busy=0, done=0, div_err=0, quotient=0, remainder=0, and clear the counter and partial remainder.
REQ-023 A reset asserted mid-RUN SHALL abort the operation, with no done pulse afterwards.
REQ-024 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-025 The macro RESTORING_DIVIDER_ZERO_CHECK_EN SHALL select divide-by-zero handling.
REQ-026 With the macro defined, an accepted start with divisor=0 SHALL go directly IDLE->DONE, setting quotient to all ones, remainder to the dividend and div_err=1, with done high the cycle after edge k+1.
REQ-027 With the macro undefined, divisor=0 SHALL run the normal WIDTH iterations, giving quotient all ones and remainder equal to the dividend, and div_err SHALL be tied to 0.

Structure
REQ-028 The shared package divider_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE), the DIV_DEFAULT_WIDTH=4 constant and the counter-width function clog2.
REQ-029 The single restoring step SHALL be a combinational sub-module div_step (inputs: partial remainder, next dividend bit, divisor; outputs: new partial remainder, quotient bit), instantiated once.

Verification
REQ-030 A bench SHALL cover, with WIDTH=4: 13/3 -> done after 5 edges, quotient=4, remainder=1, div_err=0.
REQ-031 A bench SHALL cover: 15/1 -> quotient=15, remainder=0; and 7/9 -> quotient=0, remainder=7.
REQ-032 A bench SHALL cover: 9/0 -> with the macro, done after 1 edge, quotient=15, remainder=9, div_err=1; without it, done after 5 edges, the same quotient and remainder, div_err=0.
REQ-033 A bench SHALL cover: start=1 with 12/5 pulsed again mid-RUN with 14/2 -> a single done pulse, quotient=2, remainder=2.
REQ-034 A bench SHALL cover: rst_n low 2 cycles after accepting 11/2 -> busy=0 immediately, no done pulse; a subsequent 11/2 gives quotient=5, remainder=1.
REQ-035 A bench SHALL cover: an exhaustive sweep of all 256 operand pairs with start held high -> every nonzero-divisor result matches the reference equation and done pulses are spaced 6 cycles apart.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_DEFAULT_WIDTH = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   pr_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   pr_o,
    output logic             q_o
);

    logic [WIDTH+1:0] sh;
    logic [WIDTH:0]   diff;

    // The incoming remainder is always below the divisor, so the top shifted bit only
    // matters to the compare and the subtraction result fits in WIDTH+1 bits.
    assign sh   = {pr_i, bit_i};
    assign q_o  = (sh >= {2'b00, divisor_i});
    assign diff = sh[WIDTH:0] - {1'b0, divisor_i};
    assign pr_o = q_o ? diff : sh[WIDTH:0];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per RUN cycle, MSB first.
// Define RESTORING_DIVIDER_ZERO_CHECK_EN to short-circuit divide-by-zero and raise div_err.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_err
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] dvd_q, dsr_q, quot_q, rem_q, quot_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr_i      (pr_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .pr_o      (pr_d),
        .q_o       (qbit)
    );

    // Quotient bits shift into the dividend register as its bits are consumed.
    assign quot_d = {dvd_q[WIDTH-2:0], qbit};

`ifdef RESTORING_DIVIDER_ZERO_CHECK_EN
    logic err_q;
    assign div_err = err_q;
`else
    assign div_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pr_q    <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RESTORING_DIVIDER_ZERO_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q  <= dividend;
                        dsr_q  <= divisor;
                        pr_q   <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef RESTORING_DIVIDER_ZERO_CHECK_EN
                        if (divisor == '0) begin
                            state_q <= DONE;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
`else
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    pr_q  <= pr_d;
                    dvd_q <= quot_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        quot_q  <= quot_d;
                        rem_q   <= pr_d[WIDTH-1:0];
`ifdef RESTORING_DIVIDER_ZERO_CHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4): vector table, random ops, corner sequences, exhaustive sweep.
module tb_restoring_divider;

`ifdef RESTORING_DIVIDER_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic       clk, rst_n, start;
    logic [3:0] dividend, divisor;
    logic       busy, done, div_err;
    logic [3:0] quotient, remainder;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    restoring_divider #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       e;
        int         lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic model(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic e, output int lat);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q = 4'hF;
            r = a;
        end else begin
            q = 4'(ai / bi);
            r = 4'(ai % bi);
        end
        e   = (bi == 0) && ZC;
        lat = ((bi == 0) && ZC) ? 1 : 5;
    endtask

    // Caller is positioned so that the next rising edge is the accepting edge when wait_neg=0.
    task automatic run_op(input bit wait_neg, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic ee,
                          input int elat, input string nm);
        int lat;
        if (wait_neg) @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        check({nm, "_busy"}, busy, 1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check({nm, "_lat"}, lat, elat);
        check({nm, "_q"}, quotient, eq);
        check({nm, "_r"}, remainder, er);
        check({nm, "_err"}, div_err, ee);
        @(posedge clk);
        #1;
        check({nm, "_done_pulse"}, done, 0);
        check({nm, "_q_hold"}, quotient, eq);
        check({nm, "_r_hold"}, remainder, er);
    endtask

    vec_t       vecs[8];
    logic [3:0] mq, mr;
    logic       me;
    int         mlat;

    initial begin
        int         ndone;
        logic [3:0] q1, r1;
        logic [3:0] ra, rb;
        logic [7:0] op;
        logic [7:0] pend[$];
        int         idx, guard, last_done;
        logic       prev_busy;

        vecs[0] = '{4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5};
        vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5};
        vecs[2] = '{4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 5};
        vecs[3] = '{4'd9, 4'd0, 4'd15, 4'd9, ZC, (ZC ? 1 : 5)};
        vecs[4] = '{4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5};
        vecs[5] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5};
        vecs[6] = '{4'd8, 4'd3, 4'd2, 4'd2, 1'b0, 5};
        vecs[7] = '{4'd14, 4'd7, 4'd2, 4'd0, 1'b0, 5};

        rst_n = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", div_err, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        repeat (2) @(posedge clk);

        // First op is driven together with reset release: accepted on the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            run_op(i != 0, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].lat,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            model(ra, rb, mq, mr, me, mlat);
            run_op(1'b1, ra, rb, mq, mr, me, mlat, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Second start mid-RUN must be ignored.
        @(negedge clk);
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd14; divisor = 4'd2;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; q1 = '0; r1 = '0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done) begin
                if (ndone == 0) begin q1 = quotient; r1 = remainder; end
                ndone++;
            end
        end
        check("midrun_done_count", ndone, 1);
        check("midrun_q", q1, 2);
        check("midrun_r", r1, 2);

        // Reset two cycles into an operation aborts it.
        @(negedge clk);
        dividend = 4'd11; divisor = 4'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(1'b1, 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5, "after_abort");

        // Exhaustive sweep with start held high.
        @(negedge clk);
        idx = 0;
        {dividend, divisor} = 8'd0;
        start = 1'b1;
        prev_busy = busy;
        guard = 0;
        last_done = -1;
        while ((idx < 256 || pend.size() > 0) && guard < 4000) begin
            @(posedge clk); #1;
            guard++;
            if (done) begin
                if (pend.size() == 0) begin
                    check("sweep_spurious_done", 1, 0);
                end else begin
                    op = pend.pop_front();
                    model(op[7:4], op[3:0], mq, mr, me, mlat);
                    if (op[3:0] != 4'd0)
                        check($sformatf("sweep_eq_%0d_%0d", op[7:4], op[3:0]),
                              32'(quotient) * 32'(op[3:0]) + 32'(remainder), 32'(op[7:4]));
                    check($sformatf("sweep_q_%0d_%0d", op[7:4], op[3:0]), quotient, mq);
                    check($sformatf("sweep_r_%0d_%0d", op[7:4], op[3:0]), remainder, mr);
                    check($sformatf("sweep_err_%0d_%0d", op[7:4], op[3:0]), div_err, me);
                    if (op[3:0] != 4'd0 && last_done >= 0)
                        check("sweep_gap", cyc - last_done, 6);
                    last_done = cyc;
                end
            end
            if (busy && !prev_busy) begin
                pend.push_back({dividend, divisor});
                idx++;
                if (idx < 256) {dividend, divisor} = idx[7:0];
                else start = 1'b0;
            end
            prev_busy = busy;
        end
        check("sweep_completed", (guard < 4000) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
